// File: rtl/sha256_round_core_if.sv
// Handshake bundle between the message-schedule stage and the round core.
// The master side supplies start/init/W_in; the core answers with status and digest.
interface sha256_round_core_if;
  logic         start;
  logic         init;
  logic [31:0]  W_in;
  logic         ready;
  logic [5:0]   round_idx;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  modport master (
    output start, init, W_in,
    input  ready, round_idx, busy, done, digest
  );

  modport slave (
    input  start, init, W_in,
    output ready, round_idx, busy, done, digest
  );
endinterface

// File: rtl/sha256_round_core.sv
// SHA-256 compression: 64 rounds on a..h, then fold into the chaining hash.
// round_idx and ready pace the schedule stage in lockstep.
module sha256_round_core (
  input logic                clk,
  input logic                reset,
  sha256_round_core_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ROUNDS,
    FINAL
  } state_t;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85,
    32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c,
    32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [0:7][31:0] ws_q;
  logic [0:7][31:0] hv_q;
  logic [5:0]       idx_q;
  logic             done_q;

  logic [31:0] a, b, c, d;
  logic [31:0] e, f, g, h;
  logic [31:0] s0, s1;
  logic [31:0] ch, maj;
  logic [31:0] t1, t2;

  assign a = ws_q[0];
  assign b = ws_q[1];
  assign c = ws_q[2];
  assign d = ws_q[3];
  assign e = ws_q[4];
  assign f = ws_q[5];
  assign g = ws_q[6];
  assign h = ws_q[7];

  assign s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
  assign s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
  assign ch  = (e & f) ^ (~e & g);
  assign maj = (a & b) ^ (a & c) ^ (b & c);
  assign t1  = h + s1 + ch + K[idx_q] + bus.W_in;
  assign t2  = s0 + maj;

  assign bus.round_idx = idx_q;
  assign bus.done      = done_q;
  assign bus.digest    = hv_q;

  always_comb begin
    state_d   = state_q;
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = ROUNDS;
      end
      ROUNDS: begin
        bus.ready = 1'b1;
        bus.busy  = 1'b1;
        if (idx_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        bus.busy = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ws_q    <= '0;
      hv_q    <= IV;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            ws_q  <= bus.init ? IV : hv_q;
            idx_q <= '0;
            if (bus.init) hv_q <= IV;
          end
        end
        ROUNDS: begin
          ws_q  <= {t1 + t2, a, b, c,
                    d + t1, e, f, g};
          // 6-bit index wraps 63 -> 0 on its own
          idx_q <= idx_q + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++)
            hv_q[i] <= hv_q[i] + ws_q[i];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
